// File: rtl/core_csr_access_ctrl_pkg.sv
// Shared Zicsr encodings, FSM state type and read-only address mask for the CSR access controller.
package core_csr_access_ctrl_pkg;

  localparam logic [1:0] F3_RW = 2'b01;
  localparam logic [1:0] F3_RS = 2'b10;
  localparam logic [1:0] F3_RC = 2'b11;

  // addr[11:10] == 2'b11 marks a read-only CSR
  localparam logic [1:0] CSR_RO_MASK = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_RESP  = 2'b11
  } state_t;

  function automatic logic f3_illegal(input logic [2:0] f3);
    return (f3[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/core_csr_wdata_alu.sv
// Combinational read-modify step for Zicsr ops: new CSR value and write enable.
module core_csr_wdata_alu
  import core_csr_access_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        i_op,
  input  logic [DATA_W-1:0] i_old,
  input  logic [DATA_W-1:0] i_src,
  input  logic              i_rs1_nz,
  output logic [DATA_W-1:0] o_new,
  output logic              o_wr_en
);

  always_comb begin
    o_new   = i_src;
    o_wr_en = 1'b0;
    case (i_op)
      F3_RW: begin
        o_new   = i_src;
        o_wr_en = 1'b1;
      end
      F3_RS: begin
        o_new   = i_old | i_src;
        o_wr_en = i_rs1_nz;
      end
      F3_RC: begin
        o_new   = i_old & ~i_src;
        o_wr_en = i_rs1_nz;
      end
      default: begin
        o_new   = i_src;
        o_wr_en = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/core_csr_access_ctrl.sv
// Zicsr initiator: IDLE->READ->WRITE->RESP sequencing of one CSR op against the CSR unit.
// Optional build macro CSR_RO_CHECK_EN flags enabled writes to read-only CSRs as illegal.
module core_csr_access_ctrl
  import core_csr_access_ctrl_pkg::*;
#(
  parameter int CSR_ADDR_WIDTH = 12,
  parameter int CSR_DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [2:0]                funct3_i,
  input  logic [CSR_ADDR_WIDTH-1:0] csr_addr_i,
  input  logic [4:0]                rs1_idx_i,
  input  logic [CSR_DATA_WIDTH-1:0] rs1_data_i,
  input  logic [4:0]                rd_idx_i,
  output logic [CSR_ADDR_WIDTH-1:0] csr_raddr_o,
  input  logic [CSR_DATA_WIDTH-1:0] csr_rdata_i,
  output logic [CSR_ADDR_WIDTH-1:0] csr_waddr_o,
  output logic [CSR_DATA_WIDTH-1:0] csr_wdata_o,
  output logic                      csr_wr_o,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [CSR_DATA_WIDTH-1:0] rsp_rdata_o,
  output logic [4:0]                rsp_rd_o,
  output logic                      rsp_err_o
);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [2:0]                r_funct3;
  logic [CSR_ADDR_WIDTH-1:0] r_addr;
  logic [4:0]                r_rs1_idx;
  logic [CSR_DATA_WIDTH-1:0] r_rs1_data;
  logic [4:0]                r_rd;
  logic [CSR_DATA_WIDTH-1:0] r_old;

  logic                      w_accept;
  logic [CSR_DATA_WIDTH-1:0] w_src;
  logic [CSR_DATA_WIDTH-1:0] w_new;
  logic                      w_alu_wr_en;
  logic                      w_err;
  logic                      w_wr_en;

  assign w_accept = req_valid_i && (r_state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Datapath registers carry no reset; every output using them is gated by state.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_funct3   <= funct3_i;
      r_addr     <= csr_addr_i;
      r_rs1_idx  <= rs1_idx_i;
      r_rs1_data <= rs1_data_i;
      r_rd       <= rd_idx_i;
    end
    if (r_state == ST_READ) r_old <= csr_rdata_i;
  end

  assign w_src = r_funct3[2] ? {{(CSR_DATA_WIDTH-5){1'b0}}, r_rs1_idx} : r_rs1_data;

  core_csr_wdata_alu #(
    .DATA_W (CSR_DATA_WIDTH)
  ) u_alu (
    .i_op     (r_funct3[1:0]),
    .i_old    (r_old),
    .i_src    (w_src),
    .i_rs1_nz (r_rs1_idx != 5'd0),
    .o_new    (w_new),
    .o_wr_en  (w_alu_wr_en)
  );

`ifdef CSR_RO_CHECK_EN
  logic w_ro;
  assign w_ro  = (r_addr[CSR_ADDR_WIDTH-1:CSR_ADDR_WIDTH-2] == CSR_RO_MASK);
  assign w_err = f3_illegal(r_funct3) || (w_alu_wr_en && w_ro);
`else
  assign w_err = f3_illegal(r_funct3);
`endif

  assign w_wr_en = w_alu_wr_en && !w_err;

  always_comb begin
    w_state_nxt = r_state;
    req_ready_o = 1'b0;
    csr_raddr_o = '0;
    csr_waddr_o = '0;
    csr_wdata_o = '0;
    csr_wr_o    = 1'b0;
    rsp_valid_o = 1'b0;
    rsp_rdata_o = '0;
    rsp_rd_o    = '0;
    rsp_err_o   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) w_state_nxt = ST_READ;
      end
      ST_READ: begin
        csr_raddr_o = r_addr;
        w_state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        csr_raddr_o = r_addr;
        csr_waddr_o = r_addr;
        csr_wdata_o = w_new;
        csr_wr_o    = w_wr_en;
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        csr_raddr_o = r_addr;
        rsp_valid_o = 1'b1;
        rsp_rdata_o = w_err ? '0 : r_old;
        rsp_rd_o    = r_rd;
        rsp_err_o   = w_err;
        if (rsp_ready_i) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_core_csr_access_ctrl.sv
// Directed bench for core_csr_access_ctrl with a behavioural CSR responder and an expectation queue.
module tb_core_csr_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  funct3_i;
  logic [11:0] csr_addr_i;
  logic [4:0]  rs1_idx_i;
  logic [31:0] rs1_data_i;
  logic [4:0]  rd_idx_i;
  logic [11:0] csr_raddr_o;
  logic [31:0] csr_rdata_i;
  logic [11:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;
  logic        csr_wr_o;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic [4:0]  rsp_rd_o;
  logic        rsp_err_o;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        err;
    logic        we;
    logic [31:0] wdata;
  } exp_t;
  exp_t sbq[$];

  logic [31:0] mem [0:4095];
  logic        poke_en;
  logic [11:0] poke_addr;
  logic [31:0] poke_data;

  always #5 clk = ~clk;

  core_csr_access_ctrl #(.CSR_ADDR_WIDTH(12), .CSR_DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .funct3_i(funct3_i), .csr_addr_i(csr_addr_i), .rs1_idx_i(rs1_idx_i),
    .rs1_data_i(rs1_data_i), .rd_idx_i(rd_idx_i),
    .csr_raddr_o(csr_raddr_o), .csr_rdata_i(csr_rdata_i),
    .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o), .csr_wr_o(csr_wr_o),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_rd_o(rsp_rd_o), .rsp_err_o(rsp_err_o)
  );

  // CSR responder: combinational read, read-only region silently drops writes.
  assign csr_rdata_i = mem[csr_raddr_o];

  always @(posedge clk) begin
    if (poke_en) mem[poke_addr] <= poke_data;
    else if (csr_wr_o && csr_waddr_o[11:10] != 2'b11) mem[csr_waddr_o] <= csr_wdata_o;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [11:0] a, input logic [31:0] d);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    tick();
    poke_en = 1'b0;
  endtask

  function automatic exp_t model(input logic [2:0] f3, input logic [11:0] a,
                                 input logic [4:0] idx, input logic [31:0] d,
                                 input logic [4:0] rd, input logic [31:0] old);
    exp_t e;
    logic [31:0] src;
    logic illegal;
    src = f3[2] ? {27'd0, idx} : d;
    illegal = (f3[1:0] == 2'b00);
    case (f3[1:0])
      2'b01:   e.wdata = src;
      2'b10:   e.wdata = old | src;
      2'b11:   e.wdata = old & ~src;
      default: e.wdata = 32'd0;
    endcase
    e.we  = !illegal && (f3[1:0] == 2'b01 || idx != 5'd0);
    e.err = illegal;
`ifdef CSR_RO_CHECK_EN
    if (e.we && a[11:10] == 2'b11) e.err = 1'b1;
`endif
    if (e.err) e.we = 1'b0;
    e.rdata = e.err ? 32'd0 : old;
    e.rd = rd;
    return e;
  endfunction

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [11:0] a,
                        input logic [4:0] idx, input logic [31:0] d,
                        input logic [4:0] rd, input int hold);
    exp_t e;
    sbq.push_back(model(f3, a, idx, d, rd, mem[a]));
    funct3_i = f3; csr_addr_i = a; rs1_idx_i = idx; rs1_data_i = d; rd_idx_i = rd;
    req_valid_i = 1'b1;
    chk({tag, ".req_ready"}, 32'(req_ready_o), 32'd1);
    tick();
    req_valid_i = 1'b0;
    chk({tag, ".raddr_read"}, 32'(csr_raddr_o), 32'(a));
    tick();
    e = sbq.pop_front();
    chk({tag, ".wr"}, 32'(csr_wr_o), 32'(e.we));
    if (e.we) begin
      chk({tag, ".waddr"}, 32'(csr_waddr_o), 32'(a));
      chk({tag, ".wdata"}, csr_wdata_o, e.wdata);
    end
    tick();
    for (int i = 0; i < hold; i++) begin
      req_valid_i = 1'b1;
      chk({tag, ".hold_valid"}, 32'(rsp_valid_o), 32'd1);
      chk({tag, ".hold_rdata"}, rsp_rdata_o, e.rdata);
      chk({tag, ".hold_ready"}, 32'(req_ready_o), 32'd0);
      tick();
    end
    req_valid_i = 1'b0;
    chk({tag, ".rsp_valid"}, 32'(rsp_valid_o), 32'd1);
    chk({tag, ".rsp_rdata"}, rsp_rdata_o, e.rdata);
    chk({tag, ".rsp_rd"}, 32'(rsp_rd_o), 32'(e.rd));
    chk({tag, ".rsp_err"}, 32'(rsp_err_o), 32'(e.err));
    chk({tag, ".raddr_resp"}, 32'(csr_raddr_o), 32'(a));
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    chk({tag, ".idle_valid"}, 32'(rsp_valid_o), 32'd0);
    chk({tag, ".idle_ready"}, 32'(req_ready_o), 32'd1);
  endtask

  initial begin
    rst = 1'b1; req_valid_i = 1'b0; funct3_i = 3'd0; csr_addr_i = 12'd0;
    rs1_idx_i = 5'd0; rs1_data_i = 32'd0; rd_idx_i = 5'd0; rsp_ready_i = 1'b0;
    poke_en = 1'b0; poke_addr = 12'd0; poke_data = 32'd0;
    tick(); tick();
    chk("rst.req_ready", 32'(req_ready_o), 32'd1);
    chk("rst.wr", 32'(csr_wr_o), 32'd0);
    chk("rst.rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst.rsp_err", 32'(rsp_err_o), 32'd0);
    chk("rst.rsp_rdata", rsp_rdata_o, 32'd0);
    chk("rst.rsp_rd", 32'(rsp_rd_o), 32'd0);
    chk("rst.raddr", 32'(csr_raddr_o), 32'd0);
    chk("rst.waddr", 32'(csr_waddr_o), 32'd0);
    chk("rst.wdata", csr_wdata_o, 32'd0);
    rst = 1'b0;

    poke(12'h000, 32'h0000_0005);
    poke(12'hC00, 32'h1234_5678);
    poke(12'h300, 32'h0000_000F);
    poke(12'h301, 32'h0000_0001);
    poke(12'hC01, 32'hAAAA_0001);
    poke(12'h340, 32'h0000_0077);

    run_op("csrrw",   3'b001, 12'h000, 5'd7, 32'hDEAD_BEEF, 5'd3, 0);
    run_op("rdback",  3'b010, 12'h000, 5'd0, 32'hFFFF_FFFF, 5'd4, 0);
    run_op("cycle",   3'b010, 12'hC00, 5'd0, 32'h0000_FFFF, 5'd5, 0);
    run_op("csrrci",  3'b111, 12'h300, 5'd3, 32'hFFFF_FFFF, 5'd6, 0);
    run_op("csrrsi",  3'b110, 12'h301, 5'h10, 32'd0, 5'd8, 0);
    run_op("ill100",  3'b100, 12'h300, 5'd1, 32'h1, 5'd9, 0);
    run_op("ill000",  3'b000, 12'h301, 5'd2, 32'h2, 5'd10, 0);
    run_op("ro_wr",   3'b001, 12'hC01, 5'd2, 32'h55, 5'd11, 0);
    run_op("hold",    3'b011, 12'h340, 5'd9, 32'h7, 5'd12, 5);
    run_op("csrrw_r0",3'b001, 12'h300, 5'd4, 32'h0BAD_F00D, 5'd0, 0);

    // Reset while the op sits in WRITE.
    funct3_i = 3'b001; csr_addr_i = 12'h340; rs1_idx_i = 5'd1;
    rs1_data_i = 32'h1111_2222; rd_idx_i = 5'd13;
    req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    tick();
    chk("rstw.in_write", 32'(csr_wr_o), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstw.wr", 32'(csr_wr_o), 32'd0);
    chk("rstw.ready", 32'(req_ready_o), 32'd1);
    chk("rstw.rsp_valid", 32'(rsp_valid_o), 32'd0);
    tick();
    chk("rstw.still_idle", 32'(rsp_valid_o), 32'd0);
    run_op("after_rst", 3'b010, 12'h301, 5'd0, 32'h0, 5'd14, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
